// File: rtl/tpu_feed_pkg.sv
// Shared types and constants for the patch feed path into the PE array.
package tpu_feed_pkg;

    localparam int PATCH_DIM = 7;
    localparam int WORD_W    = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [PATCH_DIM-1:0][PATCH_DIM-1:0] patch_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } seq_state_t;

    // A kernel extent of 0 is meaningless; treat it as a single row/column.
    function automatic logic [2:0] clamp_k(input logic [2:0] k);
        return (k == 3'd0) ? 3'd1 : k;
    endfunction

endpackage

// File: rtl/patch_skew_mux.sv
// Diagonal wavefront selector: for beat t, lane c carries snapshot word
// [t-c][c] when that word lies inside the active Kh x Kw window.
module patch_skew_mux
    import tpu_feed_pkg::*;
#(
    parameter int T_W = 4
) (
    input  patch_t                       snap,
    input  logic [T_W-1:0]               t,
    input  logic [2:0]                   kh,
    input  logic [2:0]                   kw,
    output word_t [PATCH_DIM-1:0]        lane_data,
    output logic  [PATCH_DIM-1:0]        lane_valid
);

    // Per-lane row select along the skewed diagonal.
    always_comb begin
        lane_data  = '0;
        lane_valid = '0;
        for (int c = 0; c < PATCH_DIM; c++) begin
            logic [T_W-1:0] row;
            row = t - T_W'(c);
            if ((3'(c) < kw) && (t >= T_W'(c)) && (row < T_W'(kh))) begin
                lane_valid[c] = 1'b1;
                lane_data[c]  = snap[row[2:0]][c];
            end
        end
    end

endmodule

// File: rtl/patch_stream_sequencer.sv
// Snapshots a 7x7 patch grid and streams its active Kh x Kw window into the
// PE array as a skewed wavefront, one beat per accepted cycle.
//
// Handshake: a beat is offered while beat_valid=1 and is consumed on a clock
// edge where out_ready=1; while out_ready=0 every output and the beat counter
// hold unchanged. beat_valid never depends on out_ready in the same cycle.
module patch_stream_sequencer
    import tpu_feed_pkg::*;
#(
    parameter int T_W = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [2:0]                    kernel_h,
    input  logic [2:0]                    kernel_w,
    input  logic [PATCH_DIM*PATCH_DIM*WORD_W-1:0] patch_in,
    input  logic                          patches_valid,
    output logic                          capture_ready,
    output logic [PATCH_DIM*WORD_W-1:0]   lane_data,
    output logic [PATCH_DIM-1:0]          lane_valid,
    output logic                          beat_valid,
    input  logic                          out_ready,
    output logic                          stream_last,
    output logic                          seq_done,
    output logic                          dropped_patch,
    output seq_state_t                    dbg_state
);

    seq_state_t      state_q, state_d;
    logic [T_W-1:0]  t_q, t_d;
    logic [2:0]      kh_q, kw_q;
    patch_t          snap_q;
    logic            capture;
    logic            dropped_q;
    logic            streaming;
    logic            last_beat;
    word_t [PATCH_DIM-1:0] mux_data;
    logic  [PATCH_DIM-1:0] mux_valid;

    assign streaming = (state_q == STREAM);
    assign last_beat = (t_q == (T_W'(kh_q) + T_W'(kw_q) - T_W'(2)));

    // State and beat counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // Next-state and counter logic; the counter only advances on an accepted beat.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (patches_valid) begin
                    capture = 1'b1;
                    t_d     = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (last_beat) state_d = DONE;
                    else           t_d     = t_q + T_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Snapshot grid and clamped kernel extents, loaded only at capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_q <= '0;
            kh_q   <= 3'd1;
            kw_q   <= 3'd1;
        end else if (capture) begin
            snap_q <= patch_t'(patch_in);
            kh_q   <= clamp_k(kernel_h);
            kw_q   <= clamp_k(kernel_w);
        end
    end

    // Registered drop flag so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dropped_q <= 1'b0;
        else          dropped_q <= patches_valid && (state_q != IDLE);
    end

    patch_skew_mux #(.T_W(T_W)) u_skew (
        .snap       (snap_q),
        .t          (t_q),
        .kh         (kh_q),
        .kw         (kw_q),
        .lane_data  (mux_data),
        .lane_valid (mux_valid)
    );

    assign capture_ready = (state_q == IDLE);
    assign beat_valid    = streaming;
    assign lane_valid    = streaming ? mux_valid : '0;
    assign lane_data     = streaming ? mux_data  : '0;
    assign stream_last   = streaming && last_beat;
    assign seq_done      = (state_q == DONE);
    assign dropped_patch = dropped_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_patch_stream_sequencer.sv
// Directed bench for patch_stream_sequencer with hand-computed beat values.
module tb_patch_stream_sequencer;
    import tpu_feed_pkg::*;

    logic                                   clk;
    logic                                   reset_n;
    logic [2:0]                             kernel_h;
    logic [2:0]                             kernel_w;
    logic [PATCH_DIM*PATCH_DIM*WORD_W-1:0]  patch_in;
    logic                                   patches_valid;
    logic                                   capture_ready;
    logic [PATCH_DIM*WORD_W-1:0]            lane_data;
    logic [PATCH_DIM-1:0]                   lane_valid;
    logic                                   beat_valid;
    logic                                   out_ready;
    logic                                   stream_last;
    logic                                   seq_done;
    logic                                   dropped_patch;
    seq_state_t                             dbg_state;

    int n_vec = 0;
    int n_err = 0;

    patch_stream_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .kernel_h      (kernel_h),
        .kernel_w      (kernel_w),
        .patch_in      (patch_in),
        .patches_valid (patches_valid),
        .capture_ready (capture_ready),
        .lane_data     (lane_data),
        .lane_valid    (lane_valid),
        .beat_valid    (beat_valid),
        .out_ready     (out_ready),
        .stream_last   (stream_last),
        .seq_done      (seq_done),
        .dropped_patch (dropped_patch),
        .dbg_state     (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [6:0] exp_valid,
                            input logic [223:0] exp_data, input logic exp_last);
        chk({tag, ".beat_valid"},  256'(beat_valid),  256'(1'b1));
        chk({tag, ".lane_valid"},  256'(lane_valid),  256'(exp_valid));
        chk({tag, ".lane_data"},   256'(lane_data),   256'(exp_data));
        chk({tag, ".stream_last"}, 256'(stream_last), 256'(exp_last));
    endtask

    // Grid with word [r][c] = base + 0x100*r + c.
    function automatic logic [1567:0] grid(input logic [31:0] base);
        logic [1567:0] g;
        g = '0;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
                g[(r*7+c)*32 +: 32] = base + 32'(256*r) + 32'(c);
        return g;
    endfunction

    task automatic capture(input logic [2:0] kh, input logic [2:0] kw, input logic [31:0] base);
        kernel_h      = kh;
        kernel_w      = kw;
        patch_in      = grid(base);
        patches_valid = 1'b1;
        tick();
        patches_valid = 1'b0;
        kernel_h      = 3'd5;
        kernel_w      = 3'd6;
        patch_in      = grid(32'h0007_0000);
    endtask

    initial begin
        reset_n       = 1'b0;
        kernel_h      = 3'd0;
        kernel_w      = 3'd0;
        patch_in      = '0;
        patches_valid = 1'b0;
        out_ready     = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset state.
        chk("rst.capture_ready", 256'(capture_ready), 256'(1'b1));
        chk("rst.beat_valid",    256'(beat_valid),    256'(1'b0));
        chk("rst.lane_valid",    256'(lane_valid),    256'(7'b0));
        chk("rst.lane_data",     256'(lane_data),     256'(0));
        chk("rst.seq_done",      256'(seq_done),      256'(1'b0));
        chk("rst.dropped",       256'(dropped_patch), 256'(1'b0));
        chk("rst.state",         256'(dbg_state),     256'(IDLE));

        // 3x3 stream, no stalls.
        capture(3'd3, 3'd3, 32'h0);
        chk("k3.capture_ready", 256'(capture_ready), 256'(1'b0));
        chk_beat("k3.t0", 7'b0000001, {192'h0, 32'h000}, 1'b0);
        tick();
        chk_beat("k3.t1", 7'b0000011, {160'h0, 32'h001, 32'h100}, 1'b0);
        tick();
        chk_beat("k3.t2", 7'b0000111, {128'h0, 32'h002, 32'h101, 32'h200}, 1'b0);
        tick();
        chk_beat("k3.t3", 7'b0000110, {128'h0, 32'h102, 32'h201, 32'h0}, 1'b0);
        tick();
        chk_beat("k3.t4", 7'b0000100, {128'h0, 32'h202, 64'h0}, 1'b1);
        tick();
        chk("k3.done.seq_done",   256'(seq_done),      256'(1'b1));
        chk("k3.done.beat_valid", 256'(beat_valid),    256'(1'b0));
        chk("k3.done.cap_ready",  256'(capture_ready), 256'(1'b0));
        tick();
        chk("k3.idle.seq_done",   256'(seq_done),      256'(1'b0));
        chk("k3.idle.cap_ready",  256'(capture_ready), 256'(1'b1));

        // 7x7 stream, 13 beats.
        capture(3'd7, 3'd7, 32'h0);
        for (int i = 0; i < 6; i++) tick();
        chk_beat("k7.t6", 7'b1111111,
                 {32'h006, 32'h105, 32'h204, 32'h303, 32'h402, 32'h501, 32'h600}, 1'b0);
        tick();
        chk_beat("k7.t7", 7'b1111110,
                 {32'h106, 32'h205, 32'h304, 32'h403, 32'h502, 32'h601, 32'h0}, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk_beat("k7.t11", 7'b1100000, {32'h506, 32'h605, 160'h0}, 1'b0);
        tick();
        chk_beat("k7.t12", 7'b1000000, {32'h606, 192'h0}, 1'b1);
        tick();
        chk("k7.seq_done", 256'(seq_done), 256'(1'b1));
        tick();
        chk("k7.cap_ready", 256'(capture_ready), 256'(1'b1));

        // 3x3 with stalls on beats 1 and 3 (two cycles each).
        capture(3'd3, 3'd3, 32'h0001_0000);
        chk_beat("st.t0", 7'b0000001, {192'h0, 32'h10000}, 1'b0);
        tick();
        out_ready = 1'b0;
        chk_beat("st.t1a", 7'b0000011, {160'h0, 32'h10001, 32'h10100}, 1'b0);
        tick();
        chk_beat("st.t1b", 7'b0000011, {160'h0, 32'h10001, 32'h10100}, 1'b0);
        tick();
        chk_beat("st.t1c", 7'b0000011, {160'h0, 32'h10001, 32'h10100}, 1'b0);
        out_ready = 1'b1;
        tick();
        chk_beat("st.t2", 7'b0000111, {128'h0, 32'h10002, 32'h10101, 32'h10200}, 1'b0);
        tick();
        out_ready = 1'b0;
        chk_beat("st.t3a", 7'b0000110, {128'h0, 32'h10102, 32'h10201, 32'h0}, 1'b0);
        tick();
        chk_beat("st.t3b", 7'b0000110, {128'h0, 32'h10102, 32'h10201, 32'h0}, 1'b0);
        tick();
        chk_beat("st.t3c", 7'b0000110, {128'h0, 32'h10102, 32'h10201, 32'h0}, 1'b0);
        out_ready = 1'b1;
        tick();
        chk_beat("st.t4", 7'b0000100, {128'h0, 32'h10202, 64'h0}, 1'b1);
        tick();
        chk("st.seq_done", 256'(seq_done), 256'(1'b1));
        tick();

        // kernel_h = 0 clamps to 1: two beats along row 0.
        capture(3'd0, 3'd2, 32'h0);
        chk_beat("kz.t0", 7'b0000001, {192'h0, 32'h000}, 1'b0);
        tick();
        chk_beat("kz.t1", 7'b0000010, {160'h0, 32'h001, 32'h0}, 1'b1);
        tick();
        chk("kz.seq_done", 256'(seq_done), 256'(1'b1));
        tick();

        // New patch offered mid-stream is dropped.
        capture(3'd3, 3'd3, 32'h0);
        tick();
        patch_in      = grid(32'h0005_0000);
        patches_valid = 1'b1;
        chk_beat("dp.t1", 7'b0000011, {160'h0, 32'h001, 32'h100}, 1'b0);
        chk("dp.t1.dropped", 256'(dropped_patch), 256'(1'b0));
        tick();
        patches_valid = 1'b0;
        chk("dp.t2.dropped", 256'(dropped_patch), 256'(1'b1));
        chk_beat("dp.t2", 7'b0000111, {128'h0, 32'h002, 32'h101, 32'h200}, 1'b0);
        tick();
        chk("dp.t3.dropped", 256'(dropped_patch), 256'(1'b0));
        chk_beat("dp.t3", 7'b0000110, {128'h0, 32'h102, 32'h201, 32'h0}, 1'b0);
        tick();
        chk_beat("dp.t4", 7'b0000100, {128'h0, 32'h202, 64'h0}, 1'b1);
        tick();
        chk("dp.seq_done", 256'(seq_done), 256'(1'b1));
        tick();

        // Asynchronous reset during beat t=3 of a 7x7 stream.
        capture(3'd7, 3'd7, 32'h0);
        tick();
        tick();
        tick();
        chk("ar.pre.beat_valid", 256'(beat_valid), 256'(1'b1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar.beat_valid",  256'(beat_valid),  256'(1'b0));
        chk("ar.lane_valid",  256'(lane_valid),  256'(7'b0));
        chk("ar.lane_data",   256'(lane_data),   256'(0));
        chk("ar.stream_last", 256'(stream_last), 256'(1'b0));
        tick();
        reset_n = 1'b1;
        tick();
        chk("ar.cap_ready", 256'(capture_ready), 256'(1'b1));
        chk("ar.seq_done0", 256'(seq_done),      256'(1'b0));
        chk("ar.state",     256'(dbg_state),     256'(IDLE));
        tick();
        chk("ar.seq_done1", 256'(seq_done),      256'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
